// File: rtl/instr_frame_pkg.sv
// rtl/instr_frame_pkg.sv - frame field widths, packed frame layout, writeback match helper
package instr_frame_pkg;

  localparam int DATA_W       = 32;
  localparam int REGADDR_W    = 5;
  localparam int RESULT_SEL_W = 3;
  localparam int FRAME_W      = 3 * DATA_W + 3 * REGADDR_W + RESULT_SEL_W + 4;

  typedef struct packed {
    logic [DATA_W-1:0]       aOperand;
    logic [REGADDR_W-1:0]    aLoc;
    logic [DATA_W-1:0]       bOperand;
    logic [REGADDR_W-1:0]    bLoc;
    logic [DATA_W-1:0]       immediateVal;
    logic                    immediateSelect;
    logic                    unsignedSelect;
    logic                    subtractEnable;
    logic [RESULT_SEL_W-1:0] resultSelect;
    logic [REGADDR_W-1:0]    writeSelect;
    logic                    writeEnable;
  } instr_frame_t;

  // Register 0 is hardwired, so a writeback to it never forwards.
  function automatic logic wb_hits(input logic                 wb_valid,
                                   input logic [REGADDR_W-1:0] wb_addr,
                                   input logic [REGADDR_W-1:0] loc);
    return wb_valid && (wb_addr != '0) && (wb_addr == loc);
  endfunction

endpackage

// File: rtl/frame_operand_patch.sv
// rtl/frame_operand_patch.sv - replaces frame operands whose source register is being written back
module frame_operand_patch
  import instr_frame_pkg::*;
(
  input  instr_frame_t         frame,
  input  logic                 wb_valid,
  input  logic [REGADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  output instr_frame_t         patched
);

  always_comb begin
    patched = frame;
    if (wb_hits(wb_valid, wb_addr, frame.aLoc)) patched.aOperand = wb_data;
    if (wb_hits(wb_valid, wb_addr, frame.bLoc)) patched.bOperand = wb_data;
  end

endmodule

// File: rtl/instruction_frame_queue.sv
// rtl/instruction_frame_queue.sv - DEPTH-entry decode-to-execute frame FIFO with writeback patching
module instruction_frame_queue
  import instr_frame_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int REGADDR_WIDTH     = 5,
  parameter int RESLT_SELCT_WIDTH = 3,
  parameter int DEPTH             = 2,
  localparam int FW    = 3 * DATA_WIDTH + 3 * REGADDR_WIDTH + RESLT_SELCT_WIDTH + 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FW-1:0]            frame_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FW-1:0]            frame_out,
  input  logic                     wb_valid,
  input  logic [REGADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     flush,
  output logic [CNT_W-1:0]         count
);

  localparam int                PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

  instr_frame_t       mem      [DEPTH];
  instr_frame_t       patched  [DEPTH];
  instr_frame_t       push_frame;
  instr_frame_t       push_patched;
  logic [DEPTH-1:0]   occupied;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_ready   = (count != FULL);
  assign out_valid  = (count != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign push_frame = frame_in;
  assign frame_out  = mem[head];

  frame_operand_patch u_push_patch (
    .frame    (push_frame),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .patched  (push_patched)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    frame_operand_patch u_patch (
      .frame    (mem[i]),
      .wb_valid (wb_valid),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .patched  (patched[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      occupied <= '0;
    end else if (flush) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      occupied <= '0;
    end else begin
      // Clear before set: a push may land in the slot a pop frees only when empty/full, never both.
      if (pop) begin
        head           <= next_ptr(head);
        occupied[head] <= 1'b0;
      end
      if (push) begin
        tail           <= next_ptr(tail);
        occupied[tail] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entries leaving this cycle were already sampled by the consumer, so they keep their old operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (tail == PTR_W'(i))) begin
          mem[i] <= push_patched;
        end else if (occupied[i] && !(pop && (head == PTR_W'(i)))) begin
          mem[i] <= patched[i];
        end
      end
    end
  end

endmodule

// File: doc/instruction_frame_queue.md
# instruction_frame_queue

Parametrised elastic queue of decoded instruction frames between decode and execute. It replaces the single-entry, per-field-write-enable frame register with a DEPTH-entry FIFO using valid/ready handshakes. Buffered entries receive writeback operand patching, so a stalled frame never carries a stale register value. A flush input drops all in-flight frames on a redirect.

## Interface
Parameters:
- DATA_WIDTH, 32, operand and immediate width
- REGADDR_WIDTH, 5, register address width
- RESLT_SELCT_WIDTH, 3, result-select field width
- DEPTH, 2, number of frame entries; any value ≥ 1

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  frame_in is presented
- in_ready  out  1  queue can accept a frame (count < DEPTH)
- frame_in  in  FRAME_W  packed frame (layout in package)
- out_valid  out  1  head entry is valid
- out_ready  in  1  consumer takes the head this cycle
- frame_out  out  FRAME_W  head entry, patched
- wb_valid  in  1  writeback result this cycle
- wb_addr  in  REGADDR_WIDTH  writeback destination register
- wb_data  in  DATA_WIDTH  writeback value
- flush  in  1  discard all entries, synchronous
- count  out  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready is a function of registered count only; there is no combinational path from out_ready.
- Storage is a circular buffer with head and tail pointers. Each pointer wraps from DEPTH-1 to 0, which works for non-power-of-two DEPTH.
- Push and pop in the same cycle:
  - count unchanged.
  - When full, push is refused because in_ready=0. The pop still occurs.
- Writeback patching applies when wb_valid && wb_addr != 0:
  - Every valid entry with aLoc == wb_addr has aOperand replaced by wb_data.
  - The same rule applies independently to bLoc and bOperand.
  - A frame being pushed in the same cycle is patched before it is stored (bypass).
  - An entry being popped in the same cycle is not patched. The consumer already sampled it.
- A writeback to wb_addr == 0 never patches.
- Patching is not gated on the immediateSelect field; a patched but unused bOperand is harmless.
- flush has priority over push, pop and patching:
  - Next cycle count=0, out_valid=0, pointers=0.
  - Storage contents are not cleared.
- When out_valid=0, frame_out is don't-care. Consumers must qualify it with out_valid.

## Timing
- Reset values:
  - count=0, out_valid=0, in_ready=1, pointers=0.
  - All storage is 0, so frame_out=0.
- Latency:
  - A frame pushed in cycle N appears at frame_out in cycle N+1 if the queue was empty.
  - Writeback patching in cycle N is visible at frame_out in cycle N+1.
- Sustained throughput is 1 frame/cycle when DEPTH ≥ 2 and the consumer is always ready. With DEPTH=1, full throughput requires a push and pop in the same cycle, which is impossible because in_ready=0 while the entry is occupied. Throughput is therefore 1 frame per 2 cycles.
- A reset assertion mid-operation takes effect immediately (asynchronous). Deassertion is synchronised externally.
- Handshake rules:
  - Producer holds frame_in stable while in_valid && !in_ready.
  - out_valid never drops without a pop or a flush.

## Structure
- Shared package instr_frame_pkg holds the field-width localparams, FRAME_W, and the packed struct instr_frame_t. Fields are MSB→LSB: aOperand, aLoc, bOperand, bLoc, immediateVal, immediateSelect, unsignedSelect, subtractEnable, resultSelect, writeSelect, writeEnable.
- FRAME_W = 3·DATA_WIDTH + 3·REGADDR_WIDTH + RESLT_SELCT_WIDTH + 4. This is 118 bits at the default parameters.
- One natural sub-module: frame_operand_patch, a combinational block that takes a frame plus the wb_* signals and returns the patched frame. It is instantiated once per entry plus once on the push path.

## Test plan
- Reset, then one push with aOperand=0x11, aLoc=3, out_ready=0 → next cycle out_valid=1, count=1, frame_out.aOperand=0x11. Then out_ready=1 → count=0 the following cycle.
- DEPTH=2: push A, B with out_ready=0 → count=2, in_ready=0. A third push is ignored. Then pop → frame_out=A, then B. C pushed during the first pop is accepted next cycle, and order A,B,C is preserved.
- Entry bLoc=7, bOperand=0x5; wb_valid=1, wb_addr=7, wb_data=0xDEAD while the entry is stalled → next cycle bOperand=0xDEAD. With wb_addr=0 instead → bOperand stays 0x5.
- Push with aLoc=4 in the same cycle as wb_addr=4, wb_data=0x99 → the stored entry shows aOperand=0x99 on its first visible cycle.
- Queue full, with flush=1, in_valid=1 and out_ready=1 in the same cycle → next cycle count=0, out_valid=0, and nothing is accepted. A subsequent push wraps correctly from pointer 0.
- DEPTH=3, 10 back-to-back frames with random out_ready → every frame is delivered in order exactly once, across pointer wrap at 2→0.
